// File: rtl/f_fetch_unit.sv
// f_fetch_unit: in-order instruction fetch with tag/data FIFOs, stall and redirect; FETCH_PERF_CNT_EN adds o_perf_bubbles
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_bubbles
`endif
);
  localparam int          PW    = (BUF_DEPTH > 2) ? 2 : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [2:0]  DEPTH = 3'(BUF_DEPTH);
  logic [31:0]   r_pc;
  logic [2:0]    r_out, r_drop, r_dcnt;
  logic [31:0]   r_tag   [BUF_DEPTH];
  logic [31:0]   r_dpc   [BUF_DEPTH];
  logic [31:0]   r_dword [BUF_DEPTH];
  logic [PW-1:0] r_tag_wr, r_tag_rd, r_dat_wr, r_dat_rd;
  logic          w_accept, w_keep, w_buf_load, w_bypass, w_push, w_pop;
  logic [2:0]    w_used;
  logic [31:0]   w_resp_tag;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (32'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_used           = r_out + r_dcnt;
  assign o_imem_req_valid = !reset && !i_redirect_valid && (w_used < DEPTH);
  assign o_imem_req_addr  = r_pc;
  assign w_accept         = o_imem_req_valid && i_imem_req_ready;
  assign w_resp_tag       = r_tag[r_tag_rd];
  // a response is kept only when no drops are pending and no flush is happening now
  assign w_keep           = i_imem_resp_valid && (r_drop == 0) && !i_redirect_valid;
  assign w_buf_load       = !i_stall && (r_dcnt != 0);
  assign w_bypass         = !i_stall && (r_dcnt == 0) && w_keep;
  assign w_push           = w_keep && !w_bypass;
  assign w_pop            = w_buf_load && !i_redirect_valid;
  // pc, outstanding count, drop count and the in-flight address tags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      r_out <= r_out + 3'(w_accept) - 3'(i_imem_resp_valid);
      if (i_imem_resp_valid) r_tag_rd <= inc(r_tag_rd);
      if (w_accept) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= inc(r_tag_wr);
      end
      if (i_redirect_valid) begin
        r_pc   <= i_redirect_pc & ~32'h3;
        r_drop <= r_out - 3'(i_imem_resp_valid);
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        if (i_imem_resp_valid && r_drop != 0) r_drop <= r_drop - 3'd1;
      end
    end
  end
  // returned {pc,word} buffer, flushed on redirect
  always_ff @(posedge clock) begin
    if (reset || i_redirect_valid) begin
      r_dcnt   <= '0;
      r_dat_wr <= '0;
      r_dat_rd <= '0;
    end else begin
      r_dcnt <= r_dcnt + 3'(w_push) - 3'(w_pop);
      if (w_pop) r_dat_rd <= inc(r_dat_rd);
      if (w_push) begin
        r_dpc[r_dat_wr]   <= w_resp_tag;
        r_dword[r_dat_wr] <= i_imem_resp_data;
        r_dat_wr          <= inc(r_dat_wr);
      end
    end
  end
  // output register: buffer head, else bypassed response, else bubble; held under stall
  always_ff @(posedge clock) begin
    if (reset) begin
      o_instr       <= NOP;
      o_instr_pc    <= '0;
      o_instr_valid <= 1'b0;
    end else if (i_redirect_valid) begin
      o_instr       <= NOP;
      o_instr_valid <= 1'b0;
    end else if (!i_stall) begin
      o_instr       <= w_buf_load ? r_dword[r_dat_rd] : w_bypass ? i_imem_resp_data : NOP;
      o_instr_pc    <= w_buf_load ? r_dpc[r_dat_rd] : w_bypass ? w_resp_tag : o_instr_pc;
      o_instr_valid <= w_buf_load || w_bypass;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  // saturating count of bubbles issued to decode
  always_ff @(posedge clock) begin
    if (reset) o_perf_bubbles <= '0;
    else if (!i_stall && !i_redirect_valid && !w_buf_load && !w_bypass && !(&o_perf_bubbles))
      o_perf_bubbles <= o_perf_bubbles + 32'd1;
  end
`endif
endmodule
